i2c_target_regif: RTL and testbench

//  I2C target (slave) that lets an external I2C controller read/write an 8-bit register space on a local bus.

---
 rtl/i2c_target_regif_pkg.sv | 26 ++
 rtl/i2c_target_regif_if.sv | 13 +
 rtl/i2c_target_regif_line_cond.sv | 72 +++++++
 rtl/i2c_target_regif.sv | 193 +++++++++++++++++++
 tb/tb_i2c_target_regif.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_regif_pkg.sv
// Shared types and constants for the I2C register-interface target.
// Optional SCL/SDA glitch filtering is enabled with I2C_TGT_GLITCH_FILTER_EN.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

  localparam logic RW_READ = 1'b1;
  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] tgt);
    return addr_byte[7:1] == tgt;
  endfunction

endpackage

// File: rtl/i2c_target_regif_if.sv
// Local register bus between the I2C target (master side) and the register file (slave side).
interface i2c_target_regif_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_we, output reg_re,
                  input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_we, input reg_re,
                  output reg_rdata);
endinterface

// File: rtl/i2c_target_regif_line_cond.sv
// Pad-line conditioner: 2-flop synchronizer, optional stable-count filter
// (I2C_TGT_GLITCH_FILTER_EN), and single-clk rise/fall pulses on the clean level.
module i2c_tgt_line_cond #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       level;

  always_comb sync_d = {sync_q[0], line_i};

`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the held level; adopt the
  // new level once FILTER_LEN of them have been seen in a row.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (32'(cnt_q) + 32'd1 >= FILTER_LEN) filt_d = sync_q[1];
      else                                  cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_comb prev_d = level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~prev_q;
  assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target exposing an 8-bit register space over a local bus; never stretches SCL.
// Define I2C_TGT_GLITCH_FILTER_EN to add FILTER_LEN-deep filtering on SCL/SDA.
module i2c_target_regif
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]  TGT_ADDR   = 7'h42,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe,
  i2c_target_regif_if.master        bus,
  output logic                      busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_tgt_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .reset_n(reset_n), .line_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_tgt_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .reset_n(reset_n), .line_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;

    // Post-write pointer advance and read-data capture both trail their strobe by one clk.
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;
    if (reg_re_q) tx_d = bus.reg_rdata;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (addr_match(shift_q, TGT_ADDR)) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                reg_re_d = (shift_q[0] == RW_READ);
              end else begin
                state_d = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              reg_addr_d = shift_q;
              sda_oe_d   = 1'b1;
              state_d    = ST_PTR_ACK;
            end else begin
              reg_wdata_d = shift_q;
              reg_we_d    = 1'b1;
              sda_oe_d    = 1'b1;
              state_d     = ST_WDATA_ACK;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q == RW_READ) begin
              // The ACK-ending fall also launches the first data bit.
              state_d   = ST_RDATA;
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WDATA;
            sda_oe_d = 1'b0;
          end
        end

        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            if (sda_lvl == ACK) begin
              reg_addr_d = reg_addr_q + 8'd1;
              reg_re_d   = 1'b1;
              bit_cnt_d  = '0;
              state_d    = ST_RDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe        = sda_oe_q;
  assign busy          = busy_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed bench for i2c_target_regif: table of write transactions plus read, abort and
// (with I2C_TGT_GLITCH_FILTER_EN) SCL-glitch sequences driven by a bit-banged controller.
module tb_i2c_target_regif;
  import i2c_tgt_pkg::*;

  localparam int unsigned Q = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;
  logic sda_oe;
  logic busy;

  i2c_target_regif_if bus ();

  assign sda_line      = sda_m & ~sda_oe;
  assign bus.reg_rdata = bus.reg_addr ^ 8'h5A;

  i2c_target_regif #(.TGT_ADDR(7'h42), .FILTER_LEN(3)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  int         re_cnt = 0;
  logic       oe_seen = 1'b0;
  logic       oe_at_high = 1'b0;

  always @(negedge clk) begin
    if (bus.reg_we) begin
      we_addr_q.push_back(bus.reg_addr);
      we_data_q.push_back(bus.reg_wdata);
    end
    if (bus.reg_re) re_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    we_addr_q.delete();
    we_data_q.delete();
    re_cnt  = 0;
    oe_seen = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    oe_at_high = sda_oe; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = (b == ACK);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_bit);
  endtask

`ifdef I2C_TGT_GLITCH_FILTER_EN
  task automatic write_bit_glitch(input logic b);
    sda_m = b; tick(2);
    scl_m = 1'b1; tick(1);
    scl_m = 1'b0; tick(2);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask
`endif

  typedef struct {
    logic [7:0]  dev;
    logic [7:0]  ptr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int unsigned acks;
    int unsigned n_we;
    logic [7:0]  a0;
    logic [7:0]  w0;
    logic [7:0]  a1;
    logic [7:0]  w1;
    logic        busy_mid;
    logic        oe_any;
    logic [7:0]  addr_end;
  } wvec_t;

  wvec_t vt[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin : main
    logic       ack;
    int         acks;
    logic [7:0] rd0, rd1;
    logic [7:0] exp_a, exp_w;

    vt[0] = '{8'h84, 8'h10, 8'hAB, 8'hCD, 4, 2, 8'h10, 8'hAB, 8'h11, 8'hCD, 1'b1, 1'b1, 8'h12};
    vt[1] = '{8'h86, 8'h55, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h12};
    vt[2] = '{8'h84, 8'hFF, 8'h11, 8'h22, 4, 2, 8'hFF, 8'h11, 8'h00, 8'h22, 1'b1, 1'b1, 8'h01};
    vt[3] = '{8'h84, 8'h7F, 8'h00, 8'hFF, 4, 2, 8'h7F, 8'h00, 8'h80, 8'hFF, 1'b1, 1'b1, 8'h81};
    vt[4] = '{8'h04, 8'h33, 8'h44, 8'h55, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h81};

    tick(3);
    check("rst_sda_oe",    32'(sda_oe),        32'd0);
    check("rst_reg_addr",  32'(bus.reg_addr),  32'h00);
    check("rst_reg_wdata", 32'(bus.reg_wdata), 32'h00);
    check("rst_reg_we",    32'(bus.reg_we),    32'd0);
    check("rst_reg_re",    32'(bus.reg_re),    32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    reset_n = 1'b1;
    tick(4);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      acks = 0;
      i2c_start();
      write_byte(vt[v].dev, ack); acks += int'(ack);
      write_byte(vt[v].ptr, ack); acks += int'(ack);
      write_byte(vt[v].d0,  ack); acks += int'(ack);
      write_byte(vt[v].d1,  ack); acks += int'(ack);
      check($sformatf("v%0d_busy_mid", v), 32'(busy), 32'(vt[v].busy_mid));
      i2c_stop();
      tick(4);
      check($sformatf("v%0d_acks", v),      32'(acks),            32'(vt[v].acks));
      check($sformatf("v%0d_we_cnt", v),    32'(we_addr_q.size()), 32'(vt[v].n_we));
      check($sformatf("v%0d_oe_seen", v),   32'(oe_seen),         32'(vt[v].oe_any));
      check($sformatf("v%0d_re_cnt", v),    32'(re_cnt),          32'd0);
      check($sformatf("v%0d_busy_end", v),  32'(busy),            32'd0);
      check($sformatf("v%0d_addr_end", v),  32'(bus.reg_addr),    32'(vt[v].addr_end));
      for (int k = 0; k < int'(vt[v].n_we); k++) begin
        exp_a = (k == 0) ? vt[v].a0 : vt[v].a1;
        exp_w = (k == 0) ? vt[v].w0 : vt[v].w1;
        check($sformatf("v%0d_we%0d_addr", v, k), 32'(we_addr_q[k]), 32'(exp_a));
        check($sformatf("v%0d_we%0d_data", v, k), 32'(we_data_q[k]), 32'(exp_w));
      end
    end

    // Combined write-pointer / repeated-start read, ACK then NACK.
    clear_mon();
    acks = 0;
    i2c_start();
    write_byte(8'h84, ack); acks += int'(ack);
    write_byte(8'h20, ack); acks += int'(ack);
    i2c_start();
    write_byte(8'h85, ack); acks += int'(ack);
    read_byte(rd0, ACK);
    check("rd_rack_release", 32'(oe_at_high), 32'd0);
    read_byte(rd1, NACK);
    check("rd_nack_release", 32'(oe_at_high), 32'd0);
    tick(3);
    check("rd_oe_after_nack", 32'(sda_oe), 32'd0);
    check("rd_busy_mid",      32'(busy),   32'd1);
    i2c_stop();
    tick(4);
    check("rd_acks",     32'(acks),              32'd3);
    check("rd_byte0",    32'(rd0),               32'h7A);
    check("rd_byte1",    32'(rd1),               32'h7B);
    check("rd_re_cnt",   32'(re_cnt),            32'd2);
    check("rd_we_cnt",   32'(we_addr_q.size()),  32'd0);
    check("rd_addr_end", 32'(bus.reg_addr),      32'h21);
    check("rd_busy_end", 32'(busy),              32'd0);

    // Reset asserted after four data bits of a write byte.
    clear_mon();
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h30, ack);
    check("ab_addr_pre", 32'(bus.reg_addr), 32'h30);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    tick(1);
    reset_n = 1'b0;
    #1;
    check("ab_sda_oe",   32'(sda_oe),        32'd0);
    check("ab_busy",     32'(busy),          32'd0);
    check("ab_reg_addr", 32'(bus.reg_addr),  32'h00);
    check("ab_state",    32'(dut.state_q),   32'(ST_IDLE));
    tick(3);
    reset_n = 1'b1;
    i2c_stop();
    tick(4);
    check("ab_we_cnt", 32'(we_addr_q.size()), 32'd0);
    clear_mon();
    acks = 0;
    i2c_start();
    write_byte(8'h84, ack); acks += int'(ack);
    write_byte(8'h30, ack); acks += int'(ack);
    write_byte(8'h5C, ack); acks += int'(ack);
    i2c_stop();
    tick(4);
    check("ab2_acks",    32'(acks),              32'd3);
    check("ab2_we_cnt",  32'(we_addr_q.size()),  32'd1);
    check("ab2_we_addr", 32'(we_addr_q[0]),      32'h30);
    check("ab2_we_data", 32'(we_data_q[0]),      32'h5C);

`ifdef I2C_TGT_GLITCH_FILTER_EN
    begin : glitch
      logic [7:0] gb;
      logic       b;
      gb = 8'hAB;
      clear_mon();
      acks = 0;
      i2c_start();
      write_byte(8'h84, ack); acks += int'(ack);
      write_byte(8'h40, ack); acks += int'(ack);
      for (int i = 7; i >= 0; i--) begin
        if (i == 4) write_bit_glitch(gb[i]);
        else        write_bit(gb[i]);
      end
      read_bit(b);
      acks += int'(b == ACK);
      i2c_stop();
      tick(4);
      check("gl_acks",    32'(acks),              32'd3);
      check("gl_we_cnt",  32'(we_addr_q.size()),  32'd1);
      check("gl_we_addr", 32'(we_addr_q[0]),      32'h40);
      check("gl_we_data", 32'(we_data_q[0]),      32'hAB);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
